// File: rtl/capacitor_model_pkg.sv
// Shared types and constants for the behavioural capacitor models.
// Both the voltage-driven and current-driven models use the companion conductance helper.
package capacitor_model_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam real TS_DEFAULT = 4e-9;
    localparam real C_DEFAULT  = 100e-9;

    // Trapezoidal companion conductance 2*C/TS.
    function automatic real companion_g(input real c, input real ts);
        return 2.0 * c / ts;
    endfunction

endpackage

// File: rtl/capacitor_v2i_real_clamp.sv
// Combinational symmetric clamp of a real value to +/-I_MAX.
// The sat flag is raised only when the input lies strictly outside the range.
module real_clamp #(
    parameter real I_MAX = 1.0
) (
    input  real  raw,
    output real  clamped,
    output logic sat
);

    always_comb begin
        clamped = raw;
        sat     = 1'b0;
        if (raw > I_MAX) begin
            clamped = I_MAX;
            sat     = 1'b1;
        end else if (raw < -I_MAX) begin
            clamped = -I_MAX;
            sat     = 1'b1;
        end
    end

endmodule

// File: rtl/capacitor_v2i.sv
// Voltage-to-current capacitor model using the trapezoidal companion form
// i[n] = G*(v[n]-v[n-1]) - i[n-1], with prime/run sequencing and output clamp.
module capacitor_v2i
    import capacitor_model_pkg::*;
#(
    parameter real TS    = TS_DEFAULT,
    parameter real C     = C_DEFAULT,
    parameter real I_MAX = 1.0,
    parameter int  CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  real              v_in,
    input  logic             v_valid,
    output real              i_out,
    output logic             i_valid,
    output logic             sat,
    output logic [CNT_W-1:0] sample_cnt
);

    localparam real G = companion_g(C, TS);

    state_t state_q;
    state_t state_d;
    real    v_prev;
    real    i_prev;
    real    raw;
    real    clamped;
    logic   clamp_sat;
    logic   accept;

    assign accept = en && v_valid && ((state_q == PRIME) || (state_q == RUN));

    always_comb begin
        raw = G * (v_in - v_prev) - i_prev;
    end

    real_clamp #(
        .I_MAX(I_MAX)
    ) u_clamp (
        .raw    (raw),
        .clamped(clamped),
        .sat    (clamp_sat)
    );

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = PRIME;
                PRIME:   if (accept) state_d = RUN;
                RUN:     state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            v_prev     <= 0.0;
            i_prev     <= 0.0;
            i_out      <= 0.0;
            i_valid    <= 1'b0;
            sat        <= 1'b0;
            sample_cnt <= '0;
        end else begin
            state_q <= state_d;
            i_valid <= 1'b0;
            // Disable drops any coincident sample; i_out and sat keep their last value.
            if (!en) begin
                v_prev     <= 0.0;
                i_prev     <= 0.0;
                sample_cnt <= '0;
            end else if (accept) begin
                v_prev  <= v_in;
                i_valid <= 1'b1;
                if (state_q == PRIME) begin
                    i_prev <= 0.0;
                    i_out  <= 0.0;
                    sat    <= 1'b0;
                end else begin
                    i_prev <= clamped;
                    i_out  <= clamped;
                    sat    <= clamp_sat;
                end
                if (sample_cnt != {CNT_W{1'b1}}) begin
                    sample_cnt <= sample_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_capacitor_v2i.sv
// Directed bench for capacitor_v2i: vector table plus reset and counter-saturation sequences.
module tb_capacitor_v2i;
    import capacitor_model_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    real         v_in = 0.0;
    logic        v_valid = 1'b0;
    real         i_out;
    logic        i_valid;
    logic        sat;
    logic [31:0] sample_cnt;

    logic        en3 = 1'b0;
    real         v3 = 0.0;
    logic        vv3 = 1'b0;
    real         i3;
    logic        iv3;
    logic        sat3;
    logic [2:0]  cnt3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    capacitor_v2i dut (
        .clk(clk), .rst(rst), .en(en), .v_in(v_in), .v_valid(v_valid),
        .i_out(i_out), .i_valid(i_valid), .sat(sat), .sample_cnt(sample_cnt)
    );

    capacitor_v2i #(.CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .en(en3), .v_in(v3), .v_valid(vv3),
        .i_out(i3), .i_valid(iv3), .sat(sat3), .sample_cnt(cnt3)
    );

    typedef struct {
        bit  en;
        bit  vv;
        real v;
        bit  ev;
        real ei;
        bit  es;
        int  ec;
    } vec_t;

    vec_t vecs[22];

    task automatic check_real(input string name, input real act, input real exp);
        real d;
        tests++;
        d = act - exp;
        if (d < 0.0) d = -d;
        if (d > 1e-9) begin
            fails++;
            $display("FAIL %s got %f expected %f", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(bit e, bit vv, real v, bit ev, real ei, bit es, int ec);
        vec_t r;
        r.en = e; r.vv = vv; r.v = v; r.ev = ev; r.ei = ei; r.es = es; r.ec = ec;
        return r;
    endfunction

    initial begin
        // IDLE cycle: a valid sample is ignored
        vecs[0]  = mk(1, 1, 0.5,   0,  0.0, 0, 0);
        // saturation
        vecs[1]  = mk(1, 1, 0.0,   1,  0.0, 0, 1);
        vecs[2]  = mk(1, 1, 0.1,   1,  1.0, 1, 2);
        vecs[3]  = mk(1, 1, 0.1,   1, -1.0, 0, 3);
        vecs[4]  = mk(1, 1, 0.2,   1,  1.0, 1, 4);
        // enable drop with coincident valid, then re-prime
        vecs[5]  = mk(0, 1, 0.9,   0,  1.0, 1, 0);
        vecs[6]  = mk(1, 0, 0.0,   0,  1.0, 1, 0);
        vecs[7]  = mk(1, 1, 0.3,   1,  0.0, 0, 1);
        vecs[8]  = mk(1, 1, 0.3,   1,  0.0, 0, 2);
        // gaps
        vecs[9]  = mk(0, 0, 0.0,   0,  0.0, 0, 0);
        vecs[10] = mk(1, 0, 0.0,   0,  0.0, 0, 0);
        vecs[11] = mk(1, 1, 0.0,   1,  0.0, 0, 1);
        vecs[12] = mk(1, 0, 0.5,   0,  0.0, 0, 1);
        vecs[13] = mk(1, 0, 0.5,   0,  0.0, 0, 1);
        vecs[14] = mk(1, 0, 0.5,   0,  0.0, 0, 1);
        vecs[15] = mk(1, 1, 0.002, 1,  0.1, 0, 2);
        // step response with trapezoidal ringing
        vecs[16] = mk(0, 0, 0.0,   0,  0.1, 0, 0);
        vecs[17] = mk(1, 0, 0.0,   0,  0.1, 0, 0);
        vecs[18] = mk(1, 1, 0.0,   1,  0.0, 0, 1);
        vecs[19] = mk(1, 1, 0.01,  1,  0.5, 0, 2);
        vecs[20] = mk(1, 1, 0.01,  1, -0.5, 0, 3);
        vecs[21] = mk(1, 1, 0.01,  1,  0.5, 0, 4);

        // reset state while rst held across edges
        tick();
        tick();
        check_real("rst_i_out", i_out, 0.0);
        check_int("rst_i_valid", i_valid, 0);
        check_int("rst_sat", sat, 0);
        check_int("rst_cnt", sample_cnt, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 22; i++) begin
            en = vecs[i].en;
            v_valid = vecs[i].vv;
            v_in = vecs[i].v;
            tick();
            check_int($sformatf("row%0d_valid", i), i_valid, vecs[i].ev);
            check_real($sformatf("row%0d_i_out", i), i_out, vecs[i].ei);
            check_int($sformatf("row%0d_sat", i), sat, vecs[i].es);
            check_int($sformatf("row%0d_cnt", i), sample_cnt, vecs[i].ec);
        end

        // async reset mid-RUN with i_out=0.5, checked before any further edge
        #2;
        rst = 1'b1;
        #1;
        check_real("async_i_out", i_out, 0.0);
        check_int("async_i_valid", i_valid, 0);
        check_int("async_sat", sat, 0);
        check_int("async_cnt", sample_cnt, 0);
        tick();
        rst = 1'b0;
        v_valid = 1'b1;
        v_in = 0.2;
        tick();
        check_int("post_rst_idle_valid", i_valid, 0);
        tick();
        check_int("reprime_valid", i_valid, 1);
        check_real("reprime_i_out", i_out, 0.0);
        check_int("reprime_cnt", sample_cnt, 1);
        v_in = 0.21;
        tick();
        check_real("after_reprime_i_out", i_out, 0.5);
        en = 1'b0;
        v_valid = 1'b0;

        // counter saturation on the 3-bit instance
        en3 = 1'b1;
        vv3 = 1'b0;
        tick();
        vv3 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            v3 = 0.001 * k;
            tick();
            check_int($sformatf("cnt3_s%0d", k), cnt3, (k > 7) ? 7 : k);
        end
        vv3 = 1'b0;
        tick();
        check_int("cnt3_hold", cnt3, 7);
        check_int("cnt3_no_valid", iv3, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
